regfile32x32: RTL
=================

# regfile32x32

Thirty-two-entry, 32-bit register file with one synchronous write port and two combinational read ports. Sits directly upstream of the 32:1 × 32-bit read multiplexers. It owns the storage and the 5-to-32 write decoder. Each read port drives one `mux32to1by32` instance from the 32 register outputs. Register 0 is hardwired to zero, so the block is MIPS-style.

## Interface
- `BYPASS`, default 1: 1 forwards same-cycle write data to a matching read port; 0 makes reads return committed contents only.
- `clk` in 1: sole clock; all state changes on its rising edge.
- `reset_n` in 1: synchronous, active-low reset; clears every register.
- `reg_write` in 1: write enable, sampled at the rising edge.
- `write_register` in 5: write address.
- `write_data` in 32: data to store.
- `read_register1` in 5: port 1 address.
- `read_register2` in 5: port 2 address.
- `read_data1` out 32: contents of `read_register1`.
- `read_data2` out 32: contents of `read_register2`.

## Operation
- Storage is 32 registers, r0–r31, each 32 bits wide.
- r0 is a constant 0. Writes to address 0 are discarded, and no storage bit is required for r0.
- Write decoder: one-hot decode of `write_register`, ANDed with `reg_write`. Exactly one of r1–r31 is enabled, or none at all.
- Register update at each rising `clk` edge, in priority order:
  - `reset_n`=0: r1–r31 ← 0, regardless of `reg_write`.
  - Otherwise, if `reg_write`=1 and `write_register`≠0: r[`write_register`] ← `write_data`.
  - Otherwise: all registers hold.
- Each read port is a 32:1 × 32 mux selecting r[`read_registerN`]. The ports are fully independent and may use the same address.
- Bypass (`BYPASS`=1):
  - Condition: `reg_write`=1, `reset_n`=1, `write_register`≠0 and `read_registerN`==`write_register`.
  - When the condition holds, `read_dataN` = `write_data` combinationally, in the same cycle.
  - Bypass is never applied to address 0, and is suppressed while `reset_n`=0.
- No X propagation: every output bit is 0 or 1 whenever its address inputs are known.

## Timing
- Read latency is 0 cycles. Outputs are combinational from the address inputs and storage, plus the bypass path when enabled.
- Write latency:
  - Data is committed at the rising edge where `reg_write`=1.
  - It is visible on a non-bypassed read immediately after that edge.
  - With `BYPASS`=1 it is also visible during the write cycle itself.
- Reset:
  - `reset_n` is sampled only at the rising edge. Deasserting it between edges has no effect until the next edge.
  - After the first edge with `reset_n`=0, both read ports return 0 for every address.
  - Reset asserted in the same cycle as a write: the reset wins, and the register reads 0 afterwards.
- Before the first reset edge, storage contents are undefined. The bench must apply reset before checking any values.
- Back-to-back writes to the same address on consecutive edges: the last write wins, with no lost or merged data.
- Simultaneous write to rK and read of rK with `BYPASS`=0: the read returns the old value until the edge, and the new value after it.

## Test plan
- **Reset clear:** write 0xDEADBEEF to r5, then hold `reset_n`=0 for one edge. Expected: `read_data1`=0 with `read_register1`=5, and all 32 addresses read 0 on both ports.
- **Full sweep:** after reset, write r[i] = 0xA5A50000 + i for i=1..31, one per cycle. Then sweep both ports over addresses 0..31 with port 2 offset by 1 (mod 32). Expected: each port reads its value, and address 0 reads 0.
- **Zero register:** `reg_write`=1, `write_register`=0, `write_data`=0xFFFFFFFF. Expected: r0 reads 0 on both ports, and r1–r31 are unchanged.
- **Write-enable gating:**
  - r7 holds 0x12345678.
  - Present `write_register`=7 and `write_data`=0xCAFEF00D with `reg_write`=0 for 3 edges: r7 still reads 0x12345678.
  - Then assert `reg_write` for one edge: r7 reads 0xCAFEF00D.
- **Bypass vs. no bypass:**
  - r9 holds 0x11111111.
  - In one cycle, write 0x22222222 to r9 with `read_register1`=`read_register2`=9.
  - `BYPASS`=1: both ports show 0x22222222 before the edge.
  - `BYPASS`=0: both ports show 0x11111111 before the edge and 0x22222222 after it.
- **Reset vs. write collision:** `reset_n`=0 and `reg_write`=1 in the same cycle, writing 0x0BADF00D to r31. Expected: r31 reads 0 after the edge, and bypass is not applied during that cycle.

Source files
------------

// File: rtl/regfile32x32.sv
// rtl/regfile32x32.sv - 32x32 register file: one synchronous write port, two combinational read ports, r0 tied to zero.

module regfile32x32_wdec (
    input  logic [4:0]  addr_i,
    input  logic        en_i,
    output logic [31:1] en_o
);
    // Address 0 has no storage, so its enable is never generated.
    always_comb begin
        en_o = '0;
        for (int i = 1; i < 32; i++) begin
            en_o[i] = en_i && (addr_i == 5'(i));
        end
    end
endmodule

module mux32to1by32 (
    input  logic [31:0][31:0] data_i,
    input  logic [4:0]        sel_i,
    output logic [31:0]       data_o
);
    assign data_o = data_i[sel_i];
endmodule

module regfile32x32 #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_write,
    input  logic [4:0]  write_register,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_register1,
    input  logic [4:0]  read_register2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2
);
    logic [31:1]       wr_en;
    logic [31:0]       regs_q [1:31];
    logic [31:0]       regs_d [1:31];
    logic [31:0][31:0] rf_view;
    logic [31:0]       mux1_data;
    logic [31:0]       mux2_data;

    regfile32x32_wdec u_wdec (
        .addr_i (write_register),
        .en_i   (reg_write),
        .en_o   (wr_en)
    );

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en[i]) begin
                regs_d[i] = write_data;
            end
        end
    end

    // Reset takes priority over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 1; i < 32; i++) begin
            if (!reset_n) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < 32; i++) begin
            rf_view[i] = regs_q[i];
        end
    end

    mux32to1by32 u_rmux1 (
        .data_i (rf_view),
        .sel_i  (read_register1),
        .data_o (mux1_data)
    );

    mux32to1by32 u_rmux2 (
        .data_i (rf_view),
        .sel_i  (read_register2),
        .data_o (mux2_data)
    );

    generate
        if (BYPASS) begin : g_bypass
            logic wr_live;
            logic byp1;
            logic byp2;
            // Forwarding only for a write that will actually commit at the next edge.
            assign wr_live    = reg_write && reset_n && (write_register != 5'd0);
            assign byp1       = wr_live && (read_register1 == write_register);
            assign byp2       = wr_live && (read_register2 == write_register);
            assign read_data1 = byp1 ? write_data : mux1_data;
            assign read_data2 = byp2 ? write_data : mux2_data;
        end else begin : g_no_bypass
            assign read_data1 = mux1_data;
            assign read_data2 = mux2_data;
        end
    endgenerate
endmodule
